// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the pipelined ripple-carry adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   calc_cw()                      : slice width for a given WIDTH and STAGES
//   slice_res_t                    : {carry, partial sum} of one slice at the
//                                    default configuration
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Slice width. Only meaningful when width is an exact multiple of stages;
  // the top level rejects any other configuration at elaboration.
  function automatic int calc_cw(input int width, input int stages);
    return width / stages;
  endfunction

  localparam int DEFAULT_CW = calc_cw(DEFAULT_WIDTH, DEFAULT_STAGES);

  typedef struct packed {
    logic                  c;
    logic [DEFAULT_CW-1:0] s;
  } slice_res_t;

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// One registered CW-bit ripple-carry add stage of pipe_adder.
// Optional feature: define ADDER_OVF_EN to add the registered ovf output.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global pipeline advance; all registers hold when low
//   vin / vout : valid bit entering / leaving this stage
//   a, b, cin  : slice operands and carry from the previous stage
//   s, cout    : registered partial sum and carry out of the slice
//   ovf        : (ADDER_OVF_EN) carry into slice MSB xor carry out, registered
// -----------------------------------------------------------------------------
module adder_slice #(
  parameter int CW = adder_pkg::DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vin,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic          vout,
  output logic [CW-1:0] s,
  output logic          cout
`ifdef ADDER_OVF_EN
  ,
  output logic          ovf
`endif
);

  // Same shape as adder_pkg::slice_res_t, sized for this instance's CW.
  typedef struct packed {
    logic          c;
    logic [CW-1:0] s;
  } res_t;

  res_t res;

  assign res = res_t'({1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin});

`ifdef ADDER_OVF_EN
  // Carry into the slice MSB is recovered from the MSB sum bit.
  logic c_msb;
  assign c_msb = a[CW-1] ^ b[CW-1] ^ res.s[CW-1];
`endif

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vout <= 1'b0;
      s    <= '0;
      cout <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (en) begin
      vout <= vin;
      s    <= res.s;
      cout <= res.c;
`ifdef ADDER_OVF_EN
      ovf  <= c_msb ^ res.c;
`endif
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
// Pipelined ripple-carry adder: WIDTH-bit operands split into STAGES slices of
// CW bits, one slice added per register stage, carry handed stage to stage.
// Valid/ready on both sides with a single global stall.
// Optional feature: define ADDER_OVF_EN to add the signed-overflow port ovf.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready depends only on pipe state
//                         and out_ready)
//   a, b, cin           : operands and carry into bit 0
//   out_valid/out_ready : output handshake
//   sum, cout           : a + b + cin modulo 2^WIDTH, and carry out of MSB
//   ovf                 : (ADDER_OVF_EN) signed overflow of the same add
// -----------------------------------------------------------------------------
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = calc_cw(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  logic en;

  // Per-stage outputs. word_st[k] holds the finished low slices 0..k followed
  // by the still-unused high slices of a; b_st[k] carries b forward unchanged.
  logic [CW-1:0]    s_st    [STAGES];
  logic             c_st    [STAGES];
  logic             v_st    [STAGES];
  logic [WIDTH-1:0] word_st [STAGES];
  logic [WIDTH-1:0] b_st    [STAGES];
`ifdef ADDER_OVF_EN
  logic             ovf_st  [STAGES];
`endif

  // The whole pipe advances together; only a valid, unaccepted result stalls.
  assign en       = !v_st[STAGES-1] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic             c_src;
    logic             v_src;
    logic [WIDTH-1:0] a_skew_q;
    logic [WIDTH-1:0] b_skew_q;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b;
      assign c_src = cin;
      assign v_src = in_valid;
    end else begin : g_tail
      assign a_src = word_st[k-1];
      assign b_src = b_st[k-1];
      assign c_src = c_st[k-1];
      assign v_src = v_st[k-1];
    end

    // Skew registers. Their contents are don't-care in invalid stages, but
    // clearing them makes sum read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_skew_q <= '0;
        b_skew_q <= '0;
      end else if (en) begin
        a_skew_q <= a_src;
        b_skew_q <= b_src;
      end
    end

    adder_slice #(.CW(CW)) u_slice (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .vin  (v_src),
      .a    (a_src[k*CW +: CW]),
      .b    (b_src[k*CW +: CW]),
      .cin  (c_src),
      .vout (v_st[k]),
      .s    (s_st[k]),
      .cout (c_st[k])
`ifdef ADDER_OVF_EN
      ,
      .ovf  (ovf_st[k])
`endif
    );

    // Slice k's sum replaces the operand bits it just consumed.
    // NOTE: the full default assignment before the partial overwrite keeps
    // this block purely combinational; a missing default would infer a latch.
    always_comb begin
      merged              = a_skew_q;
      merged[k*CW +: CW]  = s_st[k];
    end

    assign word_st[k] = merged;
    assign b_st[k]    = b_skew_q;
  end

  assign out_valid = v_st[STAGES-1];
  assign sum       = word_st[STAGES-1];
  assign cout      = c_st[STAGES-1];
`ifdef ADDER_OVF_EN
  assign ovf       = ovf_st[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder at WIDTH=32, STAGES=4. Expected results
// come from plain integer arithmetic on each accepted beat, kept in an
// in-order queue; every delivered beat is compared against the queue head.
// Define ADDER_OVF_EN for both DUT and bench to exercise ovf.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

  localparam int W   = 32;
  localparam int STG = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  pipe_adder #(.WIDTH(W), .STAGES(STG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] cs;    // {cout, sum}
    logic       ovf;
    int         cyc;   // step index of the accepting edge
  } exp_t;

  exp_t       exp_q[$];
  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         delivered = 0;
  bit         check_lat = 1'b0;
  logic [W:0] last_cs   = '0;
  logic       last_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned sum, and signed overflow as an out-of-range
  // signed integer result.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int when);
    exp_t   e;
    longint sx;
    longint sy;
    longint ss;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    ss    = sx + sy + longint'(c);
    e.cs  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    e.cyc = when;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later,
  // score any delivery, record any acceptance, then move past the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic ord, output logic acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ord;
    #1;
    acc = iv && in_ready;
    if (out_valid && ord) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sum_cout", 64'({cout, sum}), 64'(e.cs));
`ifdef ADDER_OVF_EN
        check("ovf", 64'(ovf), 64'(e.ovf));
        last_ovf = ovf;
`endif
        if (check_lat) check("latency", 64'(cyc - e.cyc), 64'(STG));
        last_cs = {cout, sum};
        delivered++;
      end
    end
    if (acc) exp_q.push_back(model(ia, ib, ic, cyc));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   i;
    int   stall;
    int   d0;
    int   refused;
    bit   seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_cout",      64'(cout),      64'(0));
`ifdef ADDER_OVF_EN
    check("rst_ovf",       64'(ovf),       64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single beat: 1 + 2, latency of STAGES edges counting the accepting one
    check_lat = 1'b1;
    step(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, acc);
    check("t1_accept", 64'(acc), 64'(1));
    drain("t1");
    check("t1_result", 64'(last_cs), 64'(33'h0_0000_0003));

    // Carry ripples through every slice
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, acc);
    drain("t2");
    check("t2_result", 64'(last_cs), 64'(33'h1_0000_0000));
`ifdef ADDER_OVF_EN
    check("t2_ovf", 64'(last_ovf), 64'(0));
`endif

    // Signed overflow at the top of the positive range
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc);
    drain("t3");
    check("t3_result", 64'(last_cs), 64'(33'h0_8000_0000));
`ifdef ADDER_OVF_EN
    check("t3_ovf", 64'(last_ovf), 64'(1));
`endif

    // Back-pressure: 8 beats, out_ready low for 3 cycles once out_valid rises
    check_lat = 1'b0;
    i     = 0;
    stall = 0;
    seen  = 1'b0;
    d0    = delivered;
    for (int t = 0; t < 60 && (i < 8 || exp_q.size() != 0); t++) begin
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      step(i < 8, 32'(i), 32'd100, 1'b0, stall == 0, acc);
      if (acc) i++;
      if (stall > 0) begin
        check("bp_in_ready_low", 64'(acc),       64'(0));
        check("bp_held_valid",   64'(out_valid), 64'(1));
        check("bp_held_sum",     64'(sum),       64'(100));
        stall--;
      end
    end
    check("bp_all_sent",      64'(i),               64'(8));
    check("bp_all_delivered", 64'(delivered - d0),  64'(8));
    check("bp_queue_empty",   64'(exp_q.size()),    64'(0));

    // Throughput: 1000 random beats, in_valid and out_ready held high
    d0      = delivered;
    refused = 0;
    for (int n = 0; n < 1000; n++) begin
      step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
      if (!acc) refused++;
    end
    check("tp_refused", 64'(refused), 64'(0));
    // Beat n is delivered in step n+STAGES, so the run ends with STAGES in flight.
    check("tp_delivered", 64'(delivered - d0), 64'(1000 - STG));
    drain("tp");

    // Mid-stream reset with 3 beats in flight, oldest waiting at the output
    for (int n = 0; n < 3; n++) step(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    check("mr_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid_cleared", 64'(out_valid), 64'(0));
    check("mr_in_ready",      64'(in_ready),  64'(1));
    exp_q.delete();
    in_valid = 1'b1;
    a        = 32'd9;
    b        = 32'd9;
    @(posedge clk);
    #1;
    check("mr_no_accept_in_rst", 64'(out_valid), 64'(0));
    #3;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_lat = 1'b1;
    for (int n = 0; n < 6; n++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b1, 32'd5, 32'd6, 1'b0, 1'b1, acc);
    drain("mr");
    check("mr_result", 64'(last_cs), 64'(11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder. It is the sequential successor to the team's gate-level half and full adders. Operands of WIDTH bits are split into STAGES equal slices. Each slice is added in its own register stage, and the carry passes from one stage to the next. Valid/ready handshakes on both sides let it sit directly in streaming datapaths, with back-pressure.

## Interface
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, 1..WIDTH. Slice width is CW = WIDTH/STAGES.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result beat is present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with ADDER_OVF_EN.

## Operation
- **Acceptance.** A beat is accepted on a rising edge where in_valid && in_ready. A beat is delivered where out_valid && out_ready.
- **Stage k (0..STAGES-1).** Adds slice k of a and b, bits [k*CW +: CW], plus the carry registered by stage k-1. Stage 0 uses cin instead.
- **Stage k registers.**
  - Its CW-bit partial sum.
  - Its carry.
  - The already-computed lower slices.
  - The still-unused upper operand slices, which are skewed forward unchanged.
  - A valid bit.
- **Arithmetic.**
  - Full result is (WIDTH+1) bits: {cout, sum}.
  - Unsigned wrap is exact. Example: 0xFFFF_FFFF + 1 gives sum 0 and cout 1.
- **Global stall.**
  - en = !v[STAGES-1] || out_ready.
  - When en = 0, every stage register, valid bit included, holds its value.
  - in_ready = en. It is combinational from out_ready, with no path from in_valid.
- **Bubbles.** With en = 1 and no accepted input, v[0] loads 0. Data registers of invalid stages may load anything; they are don't-care.
- **Outputs.**
  - out_valid = v[STAGES-1].
  - sum and cout come from the last stage.
  - sum and cout must stay stable while out_valid && !out_ready.
- **Ordering.** Results are strictly in order, with no reordering and no drop.
- **Simultaneous events.**
  - A full pipe with out_ready = 1 accepts a new beat and retires the oldest beat in the same cycle, sustaining 1 beat per cycle.
  - A full pipe with out_ready = 0 deasserts in_ready.
- **Reset mid-operation.**
  - Asserting rst clears all valid bits immediately, so in-flight beats are discarded.
  - While rst is high, in_ready = 1, but no beat is accepted.

## Timing
- **Latency.** STAGES cycles from the accepting edge to out_valid, when out_ready is held high.
- **Throughput.** 1 beat per cycle.
- **Reset values.**
  - out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - in_ready = 1, derived from the cleared valid bits.
- **Critical path.** One CW-bit ripple per stage, plus the en fan-out.

## Configuration
- **ADDER_OVF_EN defined.**
  - Port ovf exists.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - The last stage registers ovf with the same valid/stall timing as sum.
- **ADDER_OVF_EN undefined.**
  - Port ovf is absent.
  - No overflow logic is generated.

## Structure
- **Package adder_pkg.**
  - Default WIDTH and STAGES constants.
  - A typedef for the slice result struct {logic c; logic [CW-1:0] s}, parametrised through a function or localparam helper.
  - A function that computes CW from WIDTH and STAGES.
- **Sub-module adder_slice.** A registered CW-bit add stage with enable, valid in/out and carry in/out, instantiated STAGES times by a generate loop.
- **Parameter check.** A static elaboration check fails the build when WIDTH % STAGES != 0.

## Test plan
1. **Single beat, WIDTH=32, STAGES=4.** a = 0x0000_0001, b = 0x0000_0002, cin = 0, out_ready = 1 -> out_valid exactly 4 cycles later with sum = 0x0000_0003, cout = 0.
2. **Full carry propagation across all slices.** a = 0xFFFF_FFFF, b = 0x0000_0000, cin = 1 -> sum = 0x0000_0000, cout = 1. With ADDER_OVF_EN, ovf = 0.
3. **Signed overflow, with ADDER_OVF_EN.** a = 0x7FFF_FFFF, b = 0x0000_0001, cin = 0 -> sum = 0x8000_0000, cout = 0, ovf = 1.
4. **Back-pressure.** Stream 8 back-to-back beats (a = i, b = 100 for i = 0..7) while out_ready is held 0 for 3 cycles once out_valid rises.
   - in_ready drops while the pipe is full.
   - The held sum stays 100 throughout the stall.
   - Sums 100..107 arrive in order with no loss or duplication.
5. **Throughput.** 1000 random beats with in_valid and out_ready held 1.
   - One result per cycle after 4 cycles of fill.
   - Every {cout, sum} matches the reference a + b + cin.
6. **Mid-stream reset.** Pulse rst asynchronously, between edges, with 3 beats in flight.
   - out_valid goes to 0 immediately.
   - No stale results appear after reset is released.
   - The next beat, 5 + 6, yields sum = 11 after 4 cycles.
